// File: rtl/rbcount_pkg.sv
// rbcount_sampler shared types and defaults.
// Imported by the synchronizer and the sampler top.
package rbcount_pkg;

  localparam int COUNT_W       = 4;
  localparam int SYNC_STAGES_D = 2;
  localparam int STABLE_CNT_D  = 2;
  localparam int WRAP_W_D      = 8;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/rbcount_sync.sv
// Multi-bit flop synchronizer, W bits x STAGES deep.
// Synchronous active-low reset clears every stage.
module rbcount_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_ff [STAGES];

  // shift the asynchronous input through the stage chain
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++)
        r_ff[i] <= '0;
    end else begin
      r_ff[0] <= i_d;
      for (int i = 1; i < STAGES; i++)
        r_ff[i] <= r_ff[i-1];
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/rbcount_sampler.sv
// Ripple-counter sampler: sync, stability filter,
// wrap accumulator and valid/ready snapshot FSM.
module rbcount_sampler
  import rbcount_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int STABLE_CNT  = STABLE_CNT_D,
  parameter int WRAP_W      = WRAP_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] q_in,
  input  logic               snap_req,
  output logic               snap_valid,
  input  logic               snap_ready,
  output logic [COUNT_W-1:0] snap_count,
  output logic [WRAP_W-1:0]  snap_wraps,
  output logic               wrap_pulse,
  output logic               overflow
);

  localparam logic [2:0] RUN_MIN = 3'(STABLE_CNT - 1);
  localparam logic [WRAP_W-1:0] WMAX = '1;

  logic [COUNT_W-1:0] w_q_sync;
  logic [COUNT_W-1:0] r_prev;
  logic [COUNT_W-1:0] r_stable;
  logic [2:0]         r_run;
  logic [2:0]         w_held;
  logic               w_accept;
  logic               w_wrap;
  logic               r_wrap_pulse;
  logic [WRAP_W-1:0]  r_wraps;
  logic [WRAP_W-1:0]  w_base;
  logic               r_overflow;
  logic               w_hs;
  state_t             r_state;
  logic               r_valid;
  logic [COUNT_W-1:0] r_scount;
  logic [WRAP_W-1:0]  r_swraps;

  rbcount_sync #(
    .W      (COUNT_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (q_in),
    .o_q (w_q_sync)
  );

  // w_held = extra cycles the current q_sync has persisted
  assign w_held = (w_q_sync != r_prev) ? 3'd0 :
                  (r_run == 3'd7)      ? 3'd7 :
                                         r_run + 3'd1;
  assign w_accept = (w_held >= RUN_MIN) &&
                    (w_q_sync != r_stable);
  assign w_wrap = w_accept && (w_q_sync < r_stable);
  assign w_hs = r_valid && snap_ready;
  assign w_base = w_hs ? '0 : r_wraps;

  // stability filter and wrap strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev       <= '0;
      r_run        <= '0;
      r_stable     <= '0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_prev       <= w_q_sync;
      r_run        <= w_held;
      r_wrap_pulse <= w_wrap;
      if (w_accept)
        r_stable <= w_q_sync;
    end
  end

  // wrap accumulator: clear on read, then count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wraps    <= '0;
      r_overflow <= 1'b0;
    end else if (w_wrap) begin
      if (w_base == WMAX)
        r_overflow <= 1'b1;
      else
        r_wraps <= w_base + WRAP_W'(1);
    end else begin
      r_wraps <= w_base;
    end
  end

  // snapshot FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_scount <= '0;
      r_swraps <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (snap_req)
            r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_scount <= r_stable;
          r_swraps <= r_wraps;
          r_valid  <= 1'b1;
          r_state  <= HOLD;
        end
        HOLD: begin
          if (snap_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign snap_valid = r_valid;
  assign snap_count = r_scount;
  assign snap_wraps = r_swraps;
  assign wrap_pulse = r_wrap_pulse;
  assign overflow   = r_overflow;

endmodule

// File: doc/rbcount_sampler.md
# rbcount_sampler

Downstream consumer of the 4-bit ripple T-flip-flop counter. Brings the asynchronously rippling count `q` into the `clk` domain through a synchronizer and a glitch/stability filter, and detects counter wrap-around (15→0). It accumulates a saturating wrap count and offers `{count, wraps}` snapshots to a system-side reader over a valid/ready handshake.

## Interface
- `SYNC_STAGES`, default 2: flop stages per bit of `q_in`; legal values 2..4.
- `STABLE_CNT`, default 2: consecutive identical synchronized samples needed to accept a new count; legal values 1..7.
- `WRAP_W`, default 8: width of the wrap accumulator.

Ports:
- `clk`, in, 1: single clock; all state is updated on the rising edge.
- `rst`, in, 1: reset, synchronous and active-low.
- `q_in`, in, 4: ripple counter output `q`; asynchronous to `clk`.
- `snap_req`, in, 1: snapshot request; sampled only in IDLE.
- `snap_valid`, out, 1: snapshot available.
- `snap_ready`, in, 1: reader accepts the snapshot.
- `snap_count`, out, 4: captured stable count.
- `snap_wraps`, out, WRAP_W: captured wrap count.
- `wrap_pulse`, out, 1: one-cycle strobe per detected wrap.
- `overflow`, out, 1: sticky flag; the wrap accumulator saturated.

## Operation
- **Synchronizer:** each bit of `q_in` passes through `SYNC_STAGES` flops, giving `q_sync`.
- **Stability filter:**
  - `run_cnt` counts the consecutive cycles for which `q_sync` equals its previous-cycle value.
  - When `q_sync` differs from `stable` and has held for `STABLE_CNT` cycles, `stable <= q_sync`.
  - A value that changes before reaching `STABLE_CNT` is discarded and `run_cnt` restarts.
- **Wrap detection:** when `stable` updates to a value numerically lower than its old value, assert `wrap_pulse` for one cycle. A decrease of any size counts as exactly one wrap (skipped codes are tolerated).
- **Wrap accumulator `wraps`:**
  - Increments on each `wrap_pulse`.
  - Saturates at all-ones. Any wrap that arrives while saturated sets `overflow`.
  - `overflow` clears only on reset.
- **Snapshot FSM, states IDLE, CAPTURE, HOLD:**
  - IDLE: `snap_req`=1 → CAPTURE.
  - CAPTURE, one cycle: `snap_count <= stable`, `snap_wraps <= wraps` (register values before this edge's update) → HOLD.
  - HOLD: `snap_valid`=1. `snap_count` and `snap_wraps` are frozen until the handshake. When `snap_valid && snap_ready` → IDLE and `wraps` clears.
  - `snap_req` is ignored in CAPTURE and HOLD.
- **Simultaneous events:**
  - A wrap in the same cycle as the HOLD handshake sets `wraps` to 1 (clear-then-increment), so no wrap is lost.
  - A wrap in the CAPTURE cycle is not in the snapshot but stays in `wraps`.
- **Reset:** when `rst`=0 at an edge, everything returns to reset values regardless of state, including mid-HOLD; a pending snapshot is dropped.

## Timing
- Reset values:
  - `snap_valid`=0, `snap_count`=0, `snap_wraps`=0, `wrap_pulse`=0, `overflow`=0.
  - `stable`=0, `wraps`=0, `run_cnt`=0, synchronizer flops=0, FSM=IDLE.
- Acceptance latency:
  - A `q_in` change first sampled at edge N appears in `stable` at edge N+`SYNC_STAGES`+`STABLE_CNT`−1.
  - With defaults, edge N+3.
- `wrap_pulse` is asserted in the same cycle `stable` takes its lower value.
- `snap_req` at edge N:
  - CAPTURE during cycle N+1.
  - `snap_valid`=1 from edge N+2.
- Handshake completes on the edge where `snap_valid` and `snap_ready` are both 1.
  - `snap_valid`=0 the following cycle.
  - The earliest next `snap_valid` is 3 cycles after the handshake (IDLE→CAPTURE→HOLD).
- `snap_ready` while `snap_valid`=0 has no effect.
- Wrap counting is continuous; throughput is one wrap per `STABLE_CNT` cycles at most.

## Structure
- Package `rbcount_pkg` holds:
  - the FSM state enum (IDLE, CAPTURE, HOLD);
  - `COUNT_W`=4;
  - default parameter constants `SYNC_STAGES_D`, `STABLE_CNT_D`, `WRAP_W_D`.
- Sub-module `rbcount_sync`: a parameterized width × `SYNC_STAGES` flop synchronizer with synchronous active-low reset to 0. It is instanced once for `q_in`.
- Filter, wrap logic and FSM live in the top module.

## Test plan
- **Reset mid-HOLD:** with `snap_valid`=1, drive `rst`=0 for one edge → all outputs 0, FSM IDLE; with `rst`=1, `snap_req` is accepted normally.
- **Stable step:** `q_in` 0→5 held → `stable`=5 exactly 3 edges after first sampling (defaults); a `snap_req` pulse then gives `snap_valid` with `snap_count`=5, `snap_wraps`=0.
- **Glitch reject:** `q_in` 5→7 for 1 cycle then back to 5 → `stable` stays 5, `wrap_pulse` never asserts.
- **Wrap and hold:**
  - Sweep `q_in` 0..15,0 three times, two cycles per step with `STABLE_CNT`=2 → three `wrap_pulse` strobes; snapshot `snap_wraps`=3.
  - Hold `snap_ready`=0 for 10 cycles → outputs frozen.
  - `snap_ready`=1 → `wraps` clears to 0.
- **Simultaneous:** wrap coincident with handshake → next snapshot `snap_wraps`=1.
- **Saturation:** `WRAP_W`=2, five wraps without read → `snap_wraps`=3, `overflow`=1, and `overflow` persists after the read.
